seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Receive side of the multiplexed 2-digit 7-segment score interface: samples the
//  active-low anode strobes and cathode pattern, debounces each digit dwell, decodes
//  the cathode pattern back to BCD and reassembles a binary score (0-99).
//  Sits on the display bus as a monitor/loopback checker for the score display path.
// PARAMETERS
//  STABLE_CYCLES   16         consecutive identical samples before a digit is accepted (>=2)
//  TIMEOUT_CYCLES  2097152    cycles without a completed frame before stale asserts
// PORTS
//  CLK             in   1  system clock, all logic on rising edge
//  RST_BTN_N       in   1  reset, asynchronous assert, active-low
//  Anode_Activate  in   8  anode strobes, active-low; 8'b01111111=tens, 8'b10111111=ones
//  LED_in          in   7  cathode pattern, active-low, bit6..0 = a..g
//  score_out       out  8  last reassembled score, binary, 0-99
//  tens            out  4  last accepted tens BCD digit
//  ones            out  4  last accepted ones BCD digit
//  score_valid     out  1  one-cycle pulse: score_out/tens/ones just updated
//  seg_error       out  1  one-cycle pulse: accepted dwell had an undecodable pattern
//  stale           out  1  level: no frame completed for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//  - Reset: score_out=0, tens=0, ones=0, score_valid=0, seg_error=0, stale=0,
//    FSM=WAIT_TENS, stability counter=0, timeout counter=0.
//  - Inputs registered once (sample pair = {Anode_Activate, LED_in}).
//  - Stability: counter reloads to 1 when sample pair differs from previous, else
//    increments, saturating at STABLE_CYCLES. Accept event fires once, on the cycle the
//    counter reaches STABLE_CYCLES; no further accepts until the pair changes.
//  - Anode pattern other than the two legal strobes (blank 8'hFF, multi-hot, other
//    digits): counter held at 0, no accept, FSM unchanged.
//  - Cathode decode: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//    6=0100000 7=0001111 8=0000000 9=0000100; any other pattern = invalid.
//  - FSM WAIT_TENS: accept tens valid -> latch digit, go WAIT_ONES; accept ones -> ignore.
//  - FSM WAIT_ONES: accept ones valid -> score = tens*10 + ones (8-bit, max 99), update
//    score_out/tens/ones, pulse score_valid, go WAIT_TENS; accept tens valid -> overwrite
//    latched tens, stay.
//  - Invalid pattern accepted in either state: pulse seg_error, discard latched tens,
//    go WAIT_TENS; outputs keep previous values, no score_valid.
//  - Latency: score_valid asserts STABLE_CYCLES+1 rising edges after the first edge that
//    samples the ones pair (plus 2 with SEG_SYNC_IN_EN).
//  - Timeout counter clears on score_valid, else increments, saturating; stale=1 while
//    counter >= TIMEOUT_CYCLES; stale drops the cycle score_valid pulses.
//  - score_valid and seg_error never assert in the same cycle.
//  - Reset mid-dwell or mid-frame: all state to reset values, partial frame discarded.
// CONFIGURATION
//  SEG_SYNC_IN_EN  defined: two-flop synchronizer on Anode_Activate and LED_in ahead of
//                  the input register (for asynchronous/off-chip sources), +2 cycles latency.
//                  undefined: inputs taken as synchronous to CLK, single input register.
// TESTING
//  1 Drive tens=4 (1001100) for 40 cycles then ones=7 (0001111) for 40 -> score_out=47,
//    tens=4, ones=7, one score_valid pulse at ones-start + 17 cycles.
//  2 Tens=9 dwell 40 cycles, ones=3 glitch for 5 cycles, ones=9 dwell 40 -> single
//    score_valid, score_out=99; glitch produces no event.
//  3 Tens dwell with LED_in=7'b1111111 for 40 cycles -> seg_error pulse, no score_valid,
//    score_out holds prior value.
//  4 Anode_Activate=8'hFF for 1000 cycles between frames -> no events; next frame 12 ->
//    score_out=12.
//  5 RST_BTN_N low for 3 cycles after tens=5 accepted, then ones=2 dwell -> no
//    score_valid (FSM in WAIT_TENS), all outputs 0.
//  6 TIMEOUT_CYCLES=100, no frames for 120 cycles -> stale=1 from cycle 100; next valid
//    frame -> stale=0 on the score_valid cycle.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for the multiplexed 2-digit 7-segment score bus: debounces digit dwells,
// decodes cathode patterns to BCD and rebuilds the score. Define SEG_SYNC_IN_EN for off-chip sources.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2097152
) (
  input  logic       CLK,
  input  logic       RST_BTN_N,
  input  logic [7:0] Anode_Activate,
  input  logic [6:0] LED_in,
  output logic [7:0] score_out,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       score_valid,
  output logic       seg_error,
  output logic       stale
);

  localparam int unsigned PAIR_W = 15;
  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  AN_TENS = 8'b0111_1111;
  localparam logic [7:0]  AN_ONES = 8'b1011_1111;
  localparam logic [0:0]  WAIT_TENS = 1'b0;
  localparam logic [0:0]  WAIT_ONES = 1'b1;

  logic [PAIR_W-1:0] pair_in;
  logic [PAIR_W-1:0] sample_q, prev_q;

`ifdef SEG_SYNC_IN_EN
  logic [PAIR_W-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer; reset to the blank pattern so nothing is accepted during startup
  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {Anode_Activate, LED_in};
      sync2_q <= sync1_q;
    end
  end
  assign pair_in = sync2_q;
`else
  assign pair_in = {Anode_Activate, LED_in};
`endif

  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      sample_q <= '1;
      prev_q   <= '1;
    end else begin
      sample_q <= pair_in;
      prev_q   <= sample_q;
    end
  end

  // Dwell stability: accept fires once when the run length first reaches STABLE_CYCLES
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             an_legal_c, accept_d;
  logic             accept_q, acc_is_tens_q;
  logic [6:0]       acc_pat_q;

  always_comb begin
    cnt_d      = cnt_q;
    an_legal_c = (sample_q[14:7] == AN_TENS) || (sample_q[14:7] == AN_ONES);
    if (!an_legal_c)                         cnt_d = '0;
    else if (sample_q != prev_q)             cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_W'(STABLE_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
    accept_d = an_legal_c && (cnt_d == CNT_W'(STABLE_CYCLES)) && (cnt_q != CNT_W'(STABLE_CYCLES));
  end

  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      cnt_q         <= '0;
      accept_q      <= 1'b0;
      acc_is_tens_q <= 1'b0;
      acc_pat_q     <= '1;
    end else begin
      cnt_q         <= cnt_d;
      accept_q      <= accept_d;
      acc_is_tens_q <= (sample_q[14:7] == AN_TENS);
      acc_pat_q     <= sample_q[6:0];
    end
  end

  logic       dec_valid_c;
  logic [3:0] dec_digit_c;

  always_comb begin
    dec_valid_c = 1'b1;
    dec_digit_c = 4'd0;
    unique case (acc_pat_q)
      7'b0000001: dec_digit_c = 4'd0;
      7'b1001111: dec_digit_c = 4'd1;
      7'b0010010: dec_digit_c = 4'd2;
      7'b0000110: dec_digit_c = 4'd3;
      7'b1001100: dec_digit_c = 4'd4;
      7'b0100100: dec_digit_c = 4'd5;
      7'b0100000: dec_digit_c = 4'd6;
      7'b0001111: dec_digit_c = 4'd7;
      7'b0000000: dec_digit_c = 4'd8;
      7'b0000100: dec_digit_c = 4'd9;
      default:    dec_valid_c = 1'b0;
    endcase
  end

  logic [0:0]      state_q, state_d;
  logic [3:0]      tens_lat_q, tens_lat_d;
  logic [7:0]      score_d;
  logic [3:0]      tens_d, ones_d;
  logic            valid_d, err_d, stale_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;

  // Frame assembly and stale tracking
  always_comb begin
    state_d    = state_q;
    tens_lat_d = tens_lat_q;
    score_d    = score_out;
    tens_d     = tens;
    ones_d     = ones;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (accept_q) begin
      if (!dec_valid_c) begin
        err_d      = 1'b1;
        tens_lat_d = 4'd0;
        state_d    = WAIT_TENS;
      end else if (acc_is_tens_q) begin
        tens_lat_d = dec_digit_c;
        state_d    = WAIT_ONES;
      end else if (state_q == WAIT_ONES) begin
        score_d = 8'(tens_lat_q) * 8'd10 + 8'(dec_digit_c);
        tens_d  = tens_lat_q;
        ones_d  = dec_digit_c;
        valid_d = 1'b1;
        state_d = WAIT_TENS;
      end
    end
    to_inc   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + TO_W'(1);
    to_cnt_d = valid_d ? '0 : to_inc;
    stale_d  = !valid_d && (to_inc >= TO_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      state_q     <= WAIT_TENS;
      tens_lat_q  <= 4'd0;
      score_out   <= 8'd0;
      tens        <= 4'd0;
      ones        <= 4'd0;
      score_valid <= 1'b0;
      seg_error   <= 1'b0;
      stale       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      tens_lat_q  <= tens_lat_d;
      score_out   <= score_d;
      tens        <= tens_d;
      ones        <= ones_d;
      score_valid <= valid_d;
      seg_error   <= err_d;
      stale       <= stale_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule
